obstacle_sprite_engine: RTL

Parametrised obstacle renderer for the runner game's VGA path. It drives up to N_SPRITES scrolling, animated obstacles that share one external sprite ROM. Each frame every obstacle moves left by a programmable speed and respawns at the right edge when it leaves the screen. Per display pixel it outputs a registered 12-bit colour plus a visible flag to the layer mixer, and optionally flags a collision with the player layer.

---
 rtl/obstacle_sprite_engine.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/obstacle_sprite_engine.sv
// Scrolling, animated obstacle renderer sharing one external sprite ROM (3-stage pixel pipeline).
// Optional macro SPRITE_COLLIDE_EN enables the sticky obstacle/player collision flag.
module obstacle_sprite_engine #(
  parameter int unsigned N_SPRITES   = 2,
  parameter int unsigned SPR_LOG2    = 5,
  parameter int unsigned SCALE_LOG2  = 2,
  parameter int unsigned FRAMES      = 6,
  parameter int unsigned FRAME_TICKS = 20000000,
  parameter int unsigned SPAWN_X     = 1500,
  parameter int unsigned SPACING     = 640,
  parameter int unsigned BASE_Y      = 690,
  parameter logic [11:0] KEY         = 12'hC0F,
  parameter int unsigned AW          = $clog2(FRAMES) + 2 * SPR_LOG2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [11:0]   display_col,
  input  logic [10:0]   display_row,
  input  logic          visible,
  input  logic          enable,
  input  logic [3:0]    speed,
  output logic [AW-1:0] rom_addr,
  input  logic [11:0]   rom_data,
  input  logic          player_visible,
  output logic [3:0]    pix_red,
  output logic [3:0]    pix_green,
  output logic [3:0]    pix_blue,
  output logic          pix_visible,
  output logic          collide
);

  localparam int unsigned SIZE_LOG2 = SPR_LOG2 + SCALE_LOG2;
  localparam int unsigned PIX_W     = 2 * SPR_LOG2;
  localparam int unsigned ANIM_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned TICK_W    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned CW        = 13;

  logic [CW-1:0]     r_x [N_SPRITES];
  logic [TICK_W-1:0] r_tick;
  logic [ANIM_W-1:0] r_anim;
  logic              r_hit0, r_vis0, r_hit1, r_vis1;

  logic              w_frame_start;
  logic [CW-1:0]     w_col, w_row, w_speed, w_xwin, w_dx, w_dy;
  logic              w_row_hit, w_hit;
  logic [SPR_LOG2-1:0] w_ix, w_iy;
  logic [AW-1:0]     w_addr;

  assign w_frame_start = (display_col == 12'd0) && (display_row == 11'd0);
  assign w_col   = CW'(display_col);
  assign w_row   = CW'(display_row);
  assign w_speed = CW'(speed);

  // Per-frame scroll with respawn once a slot would move past column 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SPRITES; i++) r_x[i] <= CW'(SPAWN_X + i * SPACING);
    end else if (enable && w_frame_start) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        if (r_x[i] < w_speed) r_x[i] <= CW'(SPAWN_X);
        else                  r_x[i] <= r_x[i] - w_speed;
      end
    end
  end

  // Animation frame stepping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick <= '0;
      r_anim <= '0;
    end else if (enable) begin
      if (r_tick == TICK_W'(FRAME_TICKS - 1)) begin
        r_tick <= '0;
        r_anim <= (r_anim == ANIM_W'(FRAMES - 1)) ? '0 : r_anim + 1'b1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

  // Hit test, lowest-index slot wins; 13-bit compares keep x+size from wrapping
  always_comb begin
    w_row_hit = (w_row >= CW'(BASE_Y)) && (w_row < CW'(BASE_Y + (1 << SIZE_LOG2)));
    w_hit     = 1'b0;
    w_xwin    = r_x[0];
    for (int i = 0; i < N_SPRITES; i++) begin
      if (!w_hit && w_row_hit && (w_col >= r_x[i]) &&
          (w_col < r_x[i] + CW'(1 << SIZE_LOG2))) begin
        w_hit  = 1'b1;
        w_xwin = r_x[i];
      end
    end
    w_dx   = w_col - w_xwin;
    w_dy   = w_row - CW'(BASE_Y);
    w_ix   = SPR_LOG2'(w_dx >> SCALE_LOG2);
    w_iy   = SPR_LOG2'(w_dy >> SCALE_LOG2);
    w_addr = (AW'(r_anim) << PIX_W) | AW'({w_iy, w_ix});
  end

  // S0 address/flags, S1 flag delay across the ROM read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      r_hit0   <= 1'b0;
      r_vis0   <= 1'b0;
      r_hit1   <= 1'b0;
      r_vis1   <= 1'b0;
    end else begin
      rom_addr <= w_addr;
      r_hit0   <= w_hit;
      r_vis0   <= visible;
      r_hit1   <= r_hit0;
      r_vis1   <= r_vis0;
    end
  end

  // S2 colour-key and pixel output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_red     <= 4'hF;
      pix_green   <= 4'hF;
      pix_blue    <= 4'hF;
      pix_visible <= 1'b0;
    end else if (r_hit1 && r_vis1 && (rom_data != KEY)) begin
      pix_red     <= rom_data[3:0];
      pix_green   <= rom_data[7:4];
      pix_blue    <= rom_data[11:8];
      pix_visible <= 1'b1;
    end else begin
      pix_red     <= 4'hF;
      pix_green   <= 4'hF;
      pix_blue    <= 4'hF;
      pix_visible <= 1'b0;
    end
  end

`ifdef SPRITE_COLLIDE_EN
  // Sticky overlap flag, restarted at each frame start
  always_ff @(posedge clock or posedge reset) begin
    if (reset)              collide <= 1'b0;
    else if (w_frame_start) collide <= pix_visible & player_visible;
    else if (pix_visible & player_visible) collide <= 1'b1;
  end
`else
  logic w_unused_player;
  assign w_unused_player = player_visible;
  assign collide = 1'b0;
`endif

endmodule
